// File: rtl/sensor_pkg.sv
// Shared definitions for the box hit sensor path: FSM encoding, code width, priority encoder.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package sensor_pkg;

  localparam int unsigned CODE_W      = 3;
  localparam int unsigned MAX_SENSORS = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HELD    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [CODE_W-1:0] lowest_index(input logic [MAX_SENSORS-1:0] vec);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = MAX_SENSORS - 1; i >= 0; i--) begin
      if (vec[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sensor_conditioner_debounce_line.sv
// One sensor line: 2-flop synchronizer, mismatch counter, debounced stable flop.
// Latency: raw edge to stable_o edge is DEBOUNCE_CYCLES+2 cycles.
// Backpressure: none; free-running sampler.
module debounce_line #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic stable_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Two-stage synchronizer; raw_i is asynchronous to the clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive mismatching samples; flip stable on the last one, clear on any agreement.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Box hit sensor front end: per-line debounce, lowest-index code, hit strobe with post-hit lockout.
// Latency: raw edge to sensor_code/sensor_valid/hit_pulse is DEBOUNCE_CYCLES+3 cycles.
// Backpressure: none; hits arriving outside IDLE are dropped by design.
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int unsigned NUM_SENSORS     = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned LOCKOUT_CYCLES  = 2500000
) (
  input  logic                   CLOCK_50,
  input  logic                   resetn,
  input  logic [NUM_SENSORS-1:0] raw_sensor,
  output logic [CODE_W-1:0]      sensor_code,
  output logic                   sensor_valid,
  output logic                   hit_pulse,
  output logic [CODE_W-1:0]      hit_code,
  output logic                   busy
);

  // LOCKOUT_CYCLES=0 still spends one cycle in LOCKOUT, so the last count is 0 in that case.
  localparam int unsigned LOCK_W = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = (LOCKOUT_CYCLES > 0) ? LOCK_W'(LOCKOUT_CYCLES - 1) : '0;

  logic [NUM_SENSORS-1:0] stable;
  logic [NUM_SENSORS-1:0] stable_dly_q;
  logic [NUM_SENSORS-1:0] rise;
  logic [MAX_SENSORS-1:0] stable_ext, rise_ext;

  state_e              state_q, state_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic                hit_pulse_q, hit_pulse_d;
  logic [CODE_W-1:0]   hit_code_q, hit_code_d;
  logic [CODE_W-1:0]   sensor_code_q;
  logic                sensor_valid_q;

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_line
    debounce_line #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_line (
      .clk_i   (CLOCK_50),
      .rst_ni  (resetn),
      .raw_i   (raw_sensor[g]),
      .stable_o(stable[g])
    );
  end

  assign rise       = stable & ~stable_dly_q;
  assign stable_ext = MAX_SENSORS'(stable);
  assign rise_ext   = MAX_SENSORS'(rise);

  // Hit FSM: accept one hit from IDLE, wait for full release, then sit out the lockout.
  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    hit_pulse_d = 1'b0;
    hit_code_d  = hit_code_q;
    case (state_q)
      ST_IDLE: begin
        if (|rise) begin
          hit_pulse_d = 1'b1;
          hit_code_d  = lowest_index(rise_ext);
          state_d     = ST_HELD;
        end
      end
      ST_HELD: begin
        if (stable == '0) begin
          lock_cnt_d = '0;
          state_d    = ST_LOCKOUT;
        end
      end
      ST_LOCKOUT: begin
        if (lock_cnt_q >= LOCK_LAST) begin
          state_d = ST_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, edge-detect history and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      lock_cnt_q     <= '0;
      hit_pulse_q    <= 1'b0;
      hit_code_q     <= '0;
      stable_dly_q   <= '0;
      sensor_code_q  <= '0;
      sensor_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      lock_cnt_q     <= lock_cnt_d;
      hit_pulse_q    <= hit_pulse_d;
      hit_code_q     <= hit_code_d;
      stable_dly_q   <= stable;
      sensor_code_q  <= lowest_index(stable_ext);
      sensor_valid_q <= |stable;
    end
  end

  assign sensor_code  = sensor_code_q;
  assign sensor_valid = sensor_valid_q;
  assign hit_pulse    = hit_pulse_q;
  assign hit_code     = hit_code_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: directed table, multi-cycle corner sequences, random vs reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sensor_conditioner;

  localparam int N = 8;
  localparam int D = 4;
  localparam int L = 8;

  logic         CLOCK_50;
  logic         resetn;
  logic [N-1:0] raw_sensor;
  logic [2:0]   sensor_code;
  logic         sensor_valid;
  logic         hit_pulse;
  logic [2:0]   hit_code;
  logic         busy;

  int checks = 0;
  int errors = 0;

  sensor_conditioner #(
    .NUM_SENSORS    (N),
    .DEBOUNCE_CYCLES(D),
    .LOCKOUT_CYCLES (L)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .raw_sensor  (raw_sensor),
    .sensor_code (sensor_code),
    .sensor_valid(sensor_valid),
    .hit_pulse   (hit_pulse),
    .hit_code    (hit_code),
    .busy        (busy)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  // ---------------- reference model (behavioural) ----------------
  // Raw history feeds a per-line "consecutive disagreement" run length; a line's
  // stable value follows the synchronized input once the run reaches D samples.
  logic [7:0] m_s1, m_s2, m_stable, m_prev;
  int         m_run[8];
  int         m_phase;   // 0 waiting for hit, 1 hit held, 2 lockout
  int         m_remain;
  logic       m_valid, m_pulse, m_busy;
  logic [2:0] m_code, m_hit;

  function automatic logic [2:0] first_set(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0;
    for (int i = 0; i < 8; i++) m_run[i] = 0;
    m_phase = 0; m_remain = 0;
    m_valid = 0; m_pulse = 0; m_busy = 0; m_code = 0; m_hit = 0;
  endtask

  task automatic model_step(input logic [7:0] raw_in);
    logic [7:0] st, rise;
    st      = m_stable;
    rise    = st & ~m_prev;
    m_valid = (st != 0);
    m_code  = first_set(st);
    m_pulse = 1'b0;
    if (m_phase == 0) begin
      if (rise != 0) begin
        m_pulse = 1'b1;
        m_hit   = first_set(rise);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (st == 0) begin
        m_phase  = 2;
        m_remain = (L > 0) ? L : 1;
      end
    end else begin
      m_remain = m_remain - 1;
      if (m_remain == 0) m_phase = 0;
    end
    m_prev = st;
    for (int i = 0; i < 8; i++) begin
      if (m_s2[i] != st[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == D) begin
          m_stable[i] = m_s2[i];
          m_run[i]    = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2   = m_s1;
    m_s1   = raw_in;
    m_busy = (m_phase != 0);
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // One clock with raw applied; outputs sampled on the falling edge and compared to the model.
  task automatic tick(input logic [7:0] r);
    raw_sensor = r;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    model_step(r);
    chk("model sensor_valid", {31'd0, sensor_valid}, {31'd0, m_valid});
    chk("model sensor_code",  {29'd0, sensor_code},  {29'd0, m_code});
    chk("model hit_pulse",    {31'd0, hit_pulse},    {31'd0, m_pulse});
    chk("model hit_code",     {29'd0, hit_code},     {29'd0, m_hit});
    chk("model busy",         {31'd0, busy},         {31'd0, m_busy});
  endtask

  // Hold raw for n cycles; report pulse count, tick of first pulse and first valid (-1 if none).
  task automatic run_seg(input logic [7:0] r, input int n,
                         output int npulse, output int first_pulse,
                         output int first_valid, output int any_busy);
    npulse = 0; first_pulse = -1; first_valid = -1; any_busy = 0;
    for (int k = 1; k <= n; k++) begin
      tick(r);
      if (hit_pulse) begin
        npulse++;
        if (first_pulse < 0) first_pulse = k;
      end
      if (sensor_valid && first_valid < 0) first_valid = k;
      if (busy) any_busy = 1;
    end
  endtask

  typedef struct {
    logic [7:0] raw;
    logic [2:0] exp_hit;
    logic [2:0] exp_code;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int np, fp, fv, ab;
    logic [7:0] r;

    tbl[0] = '{raw: 8'h08, exp_hit: 3'd3, exp_code: 3'd3};
    tbl[1] = '{raw: 8'h44, exp_hit: 3'd2, exp_code: 3'd2};
    tbl[2] = '{raw: 8'h01, exp_hit: 3'd0, exp_code: 3'd0};
    tbl[3] = '{raw: 8'h80, exp_hit: 3'd7, exp_code: 3'd7};
    tbl[4] = '{raw: 8'hF0, exp_hit: 3'd4, exp_code: 3'd4};

    // Reset with every line struck.
    resetn     = 1'b0;
    raw_sensor = 8'hFF;
    model_reset();
    #23;
    chk("reset sensor_valid", {31'd0, sensor_valid}, 0);
    chk("reset sensor_code",  {29'd0, sensor_code},  0);
    chk("reset hit_pulse",    {31'd0, hit_pulse},    0);
    chk("reset hit_code",     {29'd0, hit_code},     0);
    chk("reset busy",         {31'd0, busy},         0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    run_seg(8'hFF, 12, np, fp, fv, ab);
    chk("held-through-reset pulses", np, 1);
    chk("held-through-reset latency", fp, 7);
    chk("held-through-reset hit_code", {29'd0, hit_code}, 0);
    chk("held-through-reset busy", {31'd0, busy}, 1);
    run_seg(8'h00, 24, np, fp, fv, ab);
    chk("release pulses", np, 0);
    chk("release busy", {31'd0, busy}, 0);

    // Single presses from idle, each followed by a full release and lockout.
    for (int t = 0; t < 5; t++) begin
      run_seg(tbl[t].raw, 20, np, fp, fv, ab);
      chk("tbl pulses", np, 1);
      chk("tbl pulse latency", fp, 7);
      chk("tbl valid latency", fv, 7);
      chk("tbl hit_code", {29'd0, hit_code}, {29'd0, tbl[t].exp_hit});
      chk("tbl sensor_code", {29'd0, sensor_code}, {29'd0, tbl[t].exp_code});
      chk("tbl busy held", {31'd0, busy}, 1);
      run_seg(8'h00, 24, np, fp, fv, ab);
      chk("tbl release pulses", np, 0);
      chk("tbl release valid", {31'd0, sensor_valid}, 0);
      chk("tbl release busy", {31'd0, busy}, 0);
    end

    // Glitch shorter than the debounce window.
    run_seg(8'h20, 3, np, fp, fv, ab);
    chk("glitch pulses a", np, 0);
    chk("glitch valid a", fv, -1);
    chk("glitch busy a", ab, 0);
    run_seg(8'h00, 10, np, fp, fv, ab);
    chk("glitch pulses b", np, 0);
    chk("glitch valid b", fv, -1);
    chk("glitch busy b", ab, 0);

    // Simultaneous rises, then drop the lower line.
    run_seg(8'h44, 20, np, fp, fv, ab);
    chk("dual pulses", np, 1);
    chk("dual hit_code", {29'd0, hit_code}, 2);
    run_seg(8'h40, 6, np, fp, fv, ab);
    chk("drop code before", {29'd0, sensor_code}, 2);
    tick(8'h40);
    chk("drop code after", {29'd0, sensor_code}, 6);
    run_seg(8'h00, 24, np, fp, fv, ab);

    // Re-press during lockout must be ignored; press after lockout is accepted.
    run_seg(8'h02, 20, np, fp, fv, ab);
    chk("lock first pulse", np, 1);
    chk("lock first code", {29'd0, hit_code}, 1);
    run_seg(8'h00, 6, np, fp, fv, ab);
    chk("lock valid still", {31'd0, sensor_valid}, 1);
    tick(8'h00);
    chk("lock valid dropped", {31'd0, sensor_valid}, 0);
    tick(8'h00);
    run_seg(8'h02, 12, np, fp, fv, ab);
    chk("lock repress pulses", np, 0);
    chk("lock repress valid", {31'd0, sensor_valid}, 1);
    chk("lock repress busy", {31'd0, busy}, 0);
    run_seg(8'h00, 24, np, fp, fv, ab);
    run_seg(8'h10, 20, np, fp, fv, ab);
    chk("after lock pulses", np, 1);
    chk("after lock latency", fp, 7);
    chk("after lock hit_code", {29'd0, hit_code}, 4);
    run_seg(8'h00, 24, np, fp, fv, ab);

    // Asynchronous reset while HELD, line kept struck.
    run_seg(8'h80, 10, np, fp, fv, ab);
    chk("pre-reset busy", {31'd0, busy}, 1);
    #2 resetn = 1'b0;
    #1;
    chk("async reset valid", {31'd0, sensor_valid}, 0);
    chk("async reset code",  {29'd0, sensor_code},  0);
    chk("async reset hit_code", {29'd0, hit_code},  0);
    chk("async reset busy",  {31'd0, busy},         0);
    model_reset();
    @(negedge CLOCK_50);
    resetn = 1'b1;
    run_seg(8'h80, 12, np, fp, fv, ab);
    chk("post-reset pulses", np, 1);
    chk("post-reset latency", fp, 7);
    chk("post-reset hit_code", {29'd0, hit_code}, 7);
    run_seg(8'h00, 24, np, fp, fv, ab);

    // Random single-bit toggles with periodic quiet gaps, checked against the model.
    r = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ((c % 250) >= 220) begin
        r = 8'h00;
      end else if ($urandom_range(0, 5) == 0) begin
        r = r ^ (8'h01 << $urandom_range(0, 7));
      end
      tick(r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
